// File: rtl/seg14_pkg.sv
// Shared definitions for the 14-segment display path.
// Bit order of every glyph is {a,b,c,d,e,f,g1,g2,h,i,j,k,l,m}:
//   a..f outer ring, g1/g2 middle bars, h upper-left diagonal,
//   i upper centre, j upper-right diagonal, k lower-left diagonal,
//   l lower centre, m lower-right diagonal.
package seg14_pkg;

  localparam int unsigned NUM_DIGITS = 12;

  // Character codes
  localparam logic [5:0] CH_SPACE = 6'd0;
  localparam logic [5:0] CH_A     = 6'd1;
  localparam logic [5:0] CH_Z     = 6'd26;
  localparam logic [5:0] CH_0     = 6'd27;
  localparam logic [5:0] CH_9     = 6'd36;

  // Reference glyphs shared with the multiplexer
  localparam logic [13:0] GLYPH_BLANK = '0;
  localparam logic [13:0] GLYPH_A     = 14'b11101111000000;
  localparam logic [13:0] GLYPH_H     = 14'b01101111000000;
  localparam logic [13:0] GLYPH_O     = 14'b11111100000000;
  localparam logic [13:0] GLYPH_X     = 14'b00000000101101;
  localparam logic [13:0] GLYPH_1     = 14'b01100000001000;

  typedef enum logic [1:0] {
    SHOW,
    LOAD,
    COMMIT
  } state_t;

endpackage

// File: rtl/seg14_font_rom.sv
// 6-bit character code -> 14-segment pattern, purely combinational.
//   code : character code (0 space, 1..26 A..Z, 27..36 digits 0..9, rest blank)
//   segm : segment pattern, {a..m} order as defined in seg14_pkg
module seg14_font_rom
  import seg14_pkg::*;
(
  input  logic [5:0]  code,
  output logic [13:0] segm
);

  logic [5:0] alpha_idx;
  logic [5:0] digit_idx;

  always_comb begin
    alpha_idx = code - CH_A;
    digit_idx = code - CH_0;
    segm      = GLYPH_BLANK;
    if (code >= CH_A && code <= CH_Z) begin
      case (alpha_idx)
        6'd0:    segm = GLYPH_A;
        6'd1:    segm = 14'b11110001010010; // B
        6'd2:    segm = 14'b10011100000000; // C
        6'd3:    segm = 14'b11110000010010; // D
        6'd4:    segm = 14'b10011110000000; // E
        6'd5:    segm = 14'b10001110000000; // F
        6'd6:    segm = 14'b10111101000000; // G
        6'd7:    segm = GLYPH_H;
        6'd8:    segm = 14'b10010000010010; // I
        6'd9:    segm = 14'b01111000000000; // J
        6'd10:   segm = 14'b00001110001001; // K
        6'd11:   segm = 14'b00011100000000; // L
        6'd12:   segm = 14'b01101100101000; // M
        6'd13:   segm = 14'b01101100100001; // N
        6'd14:   segm = GLYPH_O;
        6'd15:   segm = 14'b11001111000000; // P
        6'd16:   segm = 14'b11111100000001; // Q
        6'd17:   segm = 14'b11001111000001; // R
        6'd18:   segm = 14'b10110111000000; // S
        6'd19:   segm = 14'b10000000010010; // T
        6'd20:   segm = 14'b01111100000000; // U
        6'd21:   segm = 14'b00001100001100; // V
        6'd22:   segm = 14'b01101100000101; // W
        6'd23:   segm = GLYPH_X;
        6'd24:   segm = 14'b00000000101010; // Y
        6'd25:   segm = 14'b10010000001100; // Z
        default: segm = GLYPH_BLANK;
      endcase
    end else if (code >= CH_0 && code <= CH_9) begin
      case (digit_idx)
        6'd0:    segm = 14'b11111100001100;
        6'd1:    segm = GLYPH_1;
        6'd2:    segm = 14'b11011011000000;
        6'd3:    segm = 14'b11110001000000;
        6'd4:    segm = 14'b01100111000000;
        6'd5:    segm = 14'b10110111000000;
        6'd6:    segm = 14'b10111111000000;
        6'd7:    segm = 14'b11100000000000;
        6'd8:    segm = 14'b11111111000000;
        6'd9:    segm = 14'b11110111000000;
        default: segm = GLYPH_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg14_scroll_buffer.sv
// Message buffer and scroller feeding the 12-digit 14-segment multiplexer.
//   clk, rst_n : clock, synchronous active-low reset
//   wr_valid/wr_ready/wr_char/wr_last : host character write stream
//   scroll_en  : enables the scroll prescaler
//   dig_idx    : digit position requested by the multiplexer (0..11)
//   segm       : registered segment pattern for dig_idx (1 cycle latency)
//   loading    : high while a new message is being written
module seg14_scroll_buffer
  import seg14_pkg::*;
#(
  parameter int unsigned MSG_DEPTH  = 32,
  parameter int unsigned SCROLL_DIV = 12000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [5:0]  wr_char,
  input  logic        wr_last,
  input  logic        scroll_en,
  input  logic [3:0]  dig_idx,
  output logic [13:0] segm,
  output logic        loading
);

  localparam int unsigned AW = $clog2(MSG_DEPTH);
  localparam int unsigned LW = AW + 1;           // holds lengths 0..MSG_DEPTH
  localparam int unsigned PW = $clog2(SCROLL_DIV);

  state_t         state, state_nxt;
  logic [5:0]     ram [MSG_DEPTH];
  logic [LW-1:0]  wr_cnt;
  logic [LW-1:0]  msg_len;
  logic [AW-1:0]  offset;
  logic [PW-1:0]  presc;

  logic           accept;
  logic [AW-1:0]  wr_addr;
  logic           presc_tc;
  logic           scrolling;
  logic [LW-1:0]  idx_sum;
  logic [AW-1:0]  idx;
  logic           blank;
  logic [5:0]     rd_char;
  logic [13:0]    glyph;

  assign accept    = wr_valid && wr_ready;
  assign wr_addr   = (state == SHOW) ? '0 : wr_cnt[AW-1:0];
  assign presc_tc  = (presc == PW'(SCROLL_DIV - 1));
  assign scrolling = (msg_len >= LW'(NUM_DIGITS));

  // FSM next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    loading   = 1'b0;
    unique case (state)
      SHOW: begin
        wr_ready = 1'b1;
        if (wr_valid) state_nxt = wr_last ? COMMIT : LOAD;
      end
      LOAD: begin
        wr_ready = 1'b1;
        loading  = 1'b1;
        if (wr_valid && (wr_last || wr_cnt == LW'(MSG_DEPTH - 1)))
          state_nxt = COMMIT;
      end
      COMMIT: begin
        loading   = 1'b1;
        state_nxt = SHOW;
      end
      default: state_nxt = SHOW;
    endcase
  end

  // Message RAM, deliberately not reset
  always_ff @(posedge clk) begin
    if (accept) ram[wr_addr] <= wr_char;
  end

  // Character index: the scrolled position wraps with a single
  // conditional subtract since offset+dig_idx < 2*msg_len.
  always_comb begin
    idx_sum = {1'b0, offset} + LW'(dig_idx);
    idx     = idx_sum[AW-1:0];
    blank   = 1'b0;
    if (dig_idx >= 4'(NUM_DIGITS) || msg_len == '0) begin
      blank = 1'b1;
    end else if (scrolling) begin
      if (idx_sum >= msg_len) idx = AW'(idx_sum - msg_len);
    end else begin
      idx = AW'(dig_idx);
      if (LW'(dig_idx) >= msg_len) blank = 1'b1;
    end
  end

  assign rd_char = ram[idx];

  seg14_font_rom u_font (
    .code (rd_char),
    .segm (glyph)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= SHOW;
      wr_cnt  <= '0;
      msg_len <= '0;
      offset  <= '0;
      presc   <= '0;
      segm    <= '0;
    end else begin
      state <= state_nxt;

      if (accept) wr_cnt <= (state == SHOW) ? LW'(1) : wr_cnt + LW'(1);

      // Prescaler only runs in SHOW, so ticks during a load are lost
      // and the next message starts from a fresh count.
      if (state == COMMIT) begin
        msg_len <= wr_cnt;
        offset  <= '0;
        presc   <= '0;
      end else if (state == SHOW && scroll_en) begin
        if (presc_tc) begin
          presc <= '0;
          if (scrolling)
            offset <= ({1'b0, offset} == msg_len - LW'(1)) ? '0 : offset + AW'(1);
        end else begin
          presc <= presc + PW'(1);
        end
      end

      segm <= (loading || blank) ? '0 : glyph;
    end
  end

endmodule
